bell_round_ctrl: RTL and testbench

- N-player bell-game round controller.
- Latches the face-up cards (one per player) and arbitrates bell presses from the keypad decoder.
- Judges whether the press was correct, then applies reward or penalty to per-player signed scores.
- Declares a winner once a score margin is reached.
- Sits between the keypad decoder / card dealer and the LCD/score display logic; replaces the separate two-player right/who/score/win blocks with one clocked unit.

---
 rtl/bell_pkg.sv | 34 +++
 rtl/bell_round_ctrl_if.sv | 33 +++
 rtl/bell_arbiter.sv | 58 +++++
 rtl/bell_round_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_bell_round_ctrl.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/bell_pkg.sv
// bell_pkg: shared types, defaults and saturating helper for the bell round controller.
package bell_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_JUDGE = 3'd2,
    S_LOCK  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  typedef logic [1:0] pidx_t;

  localparam int BELL_TARGET_SUM = 5;
  localparam int BELL_PENALTY    = 1;

  // a + b clamped to the signed range of a w-bit score
  function automatic logic signed [31:0] sat_add(
    input logic signed [31:0] a,
    input logic signed [31:0] b,
    input int w
  );
    logic signed [32:0] s;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    s  = 33'(a) + 33'(b);
    hi = (33'sd1 <<< (w - 1)) - 33'sd1;
    lo = -(33'sd1 <<< (w - 1));
    if (s > hi) s = hi;
    else if (s < lo) s = lo;
    return s[31:0];
  endfunction

endpackage

// File: rtl/bell_round_ctrl_if.sv
// bell_round_ctrl_if: card/bell inputs and score/result outputs of the round controller.
interface bell_round_ctrl_if #(
  parameter int NUM_PLAYERS = 2,
  parameter int NUM_W = 3,
  parameter int COLOR_W = 2,
  parameter int SCORE_W = 9,
  parameter int POT_W = 8
);
  logic                           card_valid;
  logic [NUM_PLAYERS*COLOR_W-1:0] card_color;
  logic [NUM_PLAYERS*NUM_W-1:0]   card_num;
  logic [POT_W-1:0]               pot;
  logic [NUM_PLAYERS-1:0]         bell;
  logic [NUM_PLAYERS*SCORE_W-1:0] score;
  logic                           result_valid;
  logic [1:0]                     result_player;
  logic                           result_right;
  logic                           busy;
  logic                           winner_valid;
  logic [1:0]                     winner;

  modport master (
    output card_valid, card_color, card_num, pot, bell,
    input  score, result_valid, result_player, result_right,
    input  busy, winner_valid, winner
  );

  modport slave (
    input  card_valid, card_color, card_num, pot, bell,
    output score, result_valid, result_player, result_right,
    output busy, winner_valid, winner
  );
endinterface

// File: rtl/bell_arbiter.sv
// bell_arbiter: picks one bell press; fixed lowest-index priority,
// or round-robin from a pointer when BELL_RR_ARB_EN is defined.
module bell_arbiter
  import bell_pkg::*;
#(
  parameter int NUM_PLAYERS = 2
) (
`ifdef BELL_RR_ARB_EN
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   take_i,
`endif
  input  logic [NUM_PLAYERS-1:0] req_i,
  output logic [NUM_PLAYERS-1:0] gnt_o,
  output pidx_t                  idx_o
);

`ifdef BELL_RR_ARB_EN
  pidx_t                    ptr_q;
  logic [2*NUM_PLAYERS-1:0] rot;
  logic                     hit;

  // rotate so bit 0 is the player the pointer names
  always_comb begin
    rot   = {req_i, req_i} >> ptr_q;
    idx_o = '0;
    hit   = 1'b0;
    for (int k = 0; k < NUM_PLAYERS; k++) begin
      if (!hit && rot[k]) begin
        hit   = 1'b1;
        idx_o = pidx_t'((int'(ptr_q) + k) % NUM_PLAYERS);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
    end else if (take_i) begin
      ptr_q <= (int'(idx_o) == NUM_PLAYERS - 1) ? '0 : idx_o + 1'b1;
    end
  end
`else
  always_comb begin
    idx_o = '0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = pidx_t'(i);
    end
  end
`endif

  always_comb begin
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      gnt_o[i] = (|req_i) && (idx_o == pidx_t'(i));
    end
  end

endmodule

// File: rtl/bell_round_ctrl.sv
// bell_round_ctrl: N-player bell round controller: card latch, arbitration, judge,
// saturating scores and win detection. BELL_RR_ARB_EN selects round-robin arbitration.
module bell_round_ctrl
  import bell_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int NUM_W = 3,
  parameter int COLOR_W = 2,
  parameter int TARGET_SUM = BELL_TARGET_SUM,
  parameter int SCORE_W = 9,
  parameter int POT_W = 8,
  parameter int PENALTY = BELL_PENALTY,
  parameter int WIN_MARGIN = 50,
  parameter int LOCK_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  bell_round_ctrl_if.slave bus
);

  localparam int NC    = 1 << COLOR_W;
  localparam int SUM_W = NUM_W + 2;
  localparam int LCW   = $clog2(LOCK_CYCLES + 1);
  localparam int CCW   = NUM_PLAYERS * COLOR_W;
  localparam int CNW   = NUM_PLAYERS * NUM_W;

  typedef logic signed [SCORE_W-1:0] score_t;

  state_e                 st_q, st_d;
  logic [CCW-1:0]         col_q, col_s;
  logic [CNW-1:0]         num_q, num_s;
  logic                   seen_q;
  pidx_t                  ply_q, gnt_idx;
  logic [NUM_PLAYERS-1:0] gnt;
  logic                   right_q, right_s;
  logic [POT_W-1:0]       pot_q;
  score_t                 sc_q [NUM_PLAYERS];
  score_t                 sc_d [NUM_PLAYERS];
  logic                   res_v_q, res_r_q;
  pidx_t                  res_p_q, win_q, win_idx;
  logic                   win_v_q, win_hit, win_set;
  logic [LCW-1:0]         lock_q;
  logic                   can_grant, card_we, lock_end;
  logic [SUM_W-1:0]       sum;
  logic signed [SCORE_W:0] diff;
  logic                   lead;

  bell_arbiter #(.NUM_PLAYERS(NUM_PLAYERS)) u_arb (
`ifdef BELL_RR_ARB_EN
    .clk    (clk),
    .rst    (rst),
    .take_i (can_grant),
`endif
    .req_i  (bus.bell),
    .gnt_o  (gnt),
    .idx_o  (gnt_idx)
  );

  assign can_grant = (st_q == S_IDLE || st_q == S_ARMED) && (|gnt);
  assign card_we   = bus.card_valid && (st_q != S_DONE);
  assign lock_end  = (lock_q == LCW'(LOCK_CYCLES - 1));
  assign win_set   = (st_q == S_LOCK) && (lock_q == '0) && win_hit && !win_v_q;

  // a card strobe coinciding with the press is what the presser saw
  assign col_s = bus.card_valid ? bus.card_color : col_q;
  assign num_s = bus.card_valid ? bus.card_num : num_q;

  always_comb begin
    right_s = 1'b0;
    sum     = '0;
    for (int c = 0; c < NC; c++) begin
      sum = '0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        if (col_s[i*COLOR_W +: COLOR_W] == COLOR_W'(c))
          sum = sum + SUM_W'(num_s[i*NUM_W +: NUM_W]);
      end
      if (sum == SUM_W'(TARGET_SUM)) right_s = 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      sc_d[i] = sc_q[i];
      if (st_q == S_JUDGE) begin
        if (ply_q == pidx_t'(i))
          sc_d[i] = score_t'(sat_add(32'(sc_q[i]),
                    right_q ? 32'(pot_q) : -(PENALTY * (NUM_PLAYERS - 1)),
                    SCORE_W));
        else if (!right_q)
          sc_d[i] = score_t'(sat_add(32'(sc_q[i]), PENALTY, SCORE_W));
      end
    end
  end

  // one extra bit keeps score differences from overflowing
  always_comb begin
    win_hit = 1'b0;
    win_idx = '0;
    diff    = '0;
    lead    = 1'b0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      lead = 1'b1;
      for (int j = 0; j < NUM_PLAYERS; j++) begin
        diff = {sc_q[i][SCORE_W-1], sc_q[i]} - {sc_q[j][SCORE_W-1], sc_q[j]};
        if (j != i && !(diff > $signed((SCORE_W+1)'(WIN_MARGIN))))
          lead = 1'b0;
      end
      if (lead) begin
        win_hit = 1'b1;
        win_idx = pidx_t'(i);
      end
    end
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      S_IDLE:  if (can_grant) st_d = S_JUDGE;
               else if (bus.card_valid) st_d = S_ARMED;
      S_ARMED: if (can_grant) st_d = S_JUDGE;
      S_JUDGE: st_d = S_LOCK;
      S_LOCK:  if (lock_end)
                 st_d = (win_v_q || win_set) ? S_DONE :
                        (seen_q || bus.card_valid) ? S_ARMED : S_IDLE;
      S_DONE:  st_d = S_DONE;
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q    <= S_IDLE;
      col_q   <= '0;
      num_q   <= '0;
      seen_q  <= 1'b0;
      ply_q   <= '0;
      right_q <= 1'b0;
      pot_q   <= '0;
      for (int i = 0; i < NUM_PLAYERS; i++) sc_q[i] <= '0;
      res_v_q <= 1'b0;
      res_p_q <= '0;
      res_r_q <= 1'b0;
      win_v_q <= 1'b0;
      win_q   <= '0;
      lock_q  <= '0;
    end else begin
      st_q <= st_d;
      if (card_we) begin
        col_q  <= bus.card_color;
        num_q  <= bus.card_num;
        seen_q <= 1'b1;
      end
      if (can_grant) begin
        ply_q   <= gnt_idx;
        right_q <= right_s;
        pot_q   <= bus.pot;
      end
      for (int i = 0; i < NUM_PLAYERS; i++) sc_q[i] <= sc_d[i];
      res_v_q <= (st_q == S_JUDGE);
      if (st_q == S_JUDGE) begin
        res_p_q <= ply_q;
        res_r_q <= right_q;
      end
      if (win_set) begin
        win_v_q <= 1'b1;
        win_q   <= win_idx;
      end
      lock_q <= (st_q == S_LOCK) ? lock_q + 1'b1 : '0;
    end
  end

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_score
    assign bus.score[g*SCORE_W +: SCORE_W] = sc_q[g];
  end

  assign bus.result_valid  = res_v_q;
  assign bus.result_player = res_p_q;
  assign bus.result_right  = res_r_q;
  assign bus.busy          = (st_q == S_JUDGE) || (st_q == S_LOCK);
  assign bus.winner_valid  = win_v_q;
  assign bus.winner        = win_q;

endmodule

// File: tb/tb_bell_round_ctrl.sv
// tb_bell_round_ctrl: directed + randomized bench against a cycle-level game model.
// Define BELL_RR_ARB_EN for bench and RTL together to cover round-robin arbitration.
module tb_bell_round_ctrl;

  localparam int NP = 2;
  localparam int NW = 3;
  localparam int CW = 2;
  localparam int SW = 9;
  localparam int PW = 8;
  localparam int LC = 4;
  localparam int WM = 50;
  localparam int PEN = 1;
  localparam int TS = 5;
  localparam int SMAX = 255;
  localparam int SMIN = -256;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  bell_round_ctrl_if #(
    .NUM_PLAYERS(NP), .NUM_W(NW), .COLOR_W(CW), .SCORE_W(SW), .POT_W(PW)
  ) bus ();

  bell_round_ctrl #(
    .NUM_PLAYERS(NP), .NUM_W(NW), .COLOR_W(CW), .TARGET_SUM(TS),
    .SCORE_W(SW), .POT_W(PW), .PENALTY(PEN), .WIN_MARGIN(WM),
    .LOCK_CYCLES(LC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // game model: scores, cards, cycles left in which bells are ignored
  int m_col[NP];
  int m_num[NP];
  int m_sc[NP];
  int m_quiet, m_app_p, m_app_pot, m_w, m_rp;
  bit m_app, m_app_r, m_wchk, m_wv, m_rv, m_rr;
`ifdef BELL_RR_ARB_EN
  int m_ptr;
`endif

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > SMAX) ? SMAX : ((v < SMIN) ? SMIN : v);
  endfunction

  function automatic int sc(input int i);
    logic signed [SW-1:0] v;
    v = bus.score[i*SW +: SW];
    return int'(v);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin
      m_col[i] = 0; m_num[i] = 0; m_sc[i] = 0;
    end
    m_quiet = 0; m_app = 0; m_wchk = 0; m_wv = 0; m_rv = 0;
    m_app_p = 0; m_app_r = 0; m_app_pot = 0; m_w = 0; m_rp = 0; m_rr = 0;
`ifdef BELL_RR_ARB_EN
    m_ptr = 0;
`endif
  endtask

  function automatic int pick(input logic [NP-1:0] b);
    int g;
    g = -1;
`ifdef BELL_RR_ARB_EN
    for (int k = 0; k < NP; k++)
      if (g < 0 && b[(m_ptr + k) % NP]) g = (m_ptr + k) % NP;
`else
    for (int k = NP - 1; k >= 0; k--)
      if (b[k]) g = k;
`endif
    return g;
  endfunction

  task automatic model_edge(input logic cv, input logic [NP*CW-1:0] c,
                            input logic [NP*NW-1:0] n, input logic [PW-1:0] p,
                            input logic [NP-1:0] b);
    bit done_pre, right, lead;
    int sums[1<<CW];
    int g;
    done_pre = m_wv && m_quiet == 0;
    m_rv = 0;
    if (m_wchk) begin
      m_wchk = 0;
      for (int i = 0; i < NP; i++) begin
        lead = 1;
        for (int j = 0; j < NP; j++)
          if (j != i && m_sc[i] - m_sc[j] <= WM) lead = 0;
        if (lead) begin m_wv = 1; m_w = i; end
      end
    end
    if (m_app) begin
      m_app = 0; m_rv = 1; m_rp = m_app_p; m_rr = m_app_r; m_wchk = 1;
      for (int i = 0; i < NP; i++) begin
        if (i == m_app_p)
          m_sc[i] = sat(m_sc[i] + (m_app_r ? m_app_pot : -PEN * (NP - 1)));
        else if (!m_app_r)
          m_sc[i] = sat(m_sc[i] + PEN);
      end
    end
    if (cv && !done_pre)
      for (int i = 0; i < NP; i++) begin
        m_col[i] = int'(c[i*CW +: CW]);
        m_num[i] = int'(n[i*NW +: NW]);
      end
    if (m_quiet == 0 && !m_wv && b != '0) begin
      g = pick(b);
`ifdef BELL_RR_ARB_EN
      m_ptr = (g + 1) % NP;
`endif
      for (int k = 0; k < (1 << CW); k++) sums[k] = 0;
      for (int i = 0; i < NP; i++) sums[m_col[i]] += m_num[i];
      right = 0;
      for (int k = 0; k < (1 << CW); k++) if (sums[k] == TS) right = 1;
      m_app = 1; m_app_p = g; m_app_r = right; m_app_pot = int'(p);
      m_quiet = LC + 1;
    end else if (m_quiet > 0) begin
      m_quiet--;
    end
  endtask

  task automatic check_outs();
    chk("result_valid", int'(bus.result_valid), int'(m_rv));
    if (m_rv) begin
      chk("result_player", int'(bus.result_player), m_rp);
      chk("result_right", int'(bus.result_right), int'(m_rr));
    end
    chk("busy", int'(bus.busy), int'(m_quiet > 0));
    chk("winner_valid", int'(bus.winner_valid), int'(m_wv));
    if (m_wv) chk("winner", int'(bus.winner), m_w);
    for (int i = 0; i < NP; i++) chk($sformatf("score%0d", i), sc(i), m_sc[i]);
  endtask

  task automatic tick(input logic cv, input logic [NP*CW-1:0] c,
                      input logic [NP*NW-1:0] n, input logic [PW-1:0] p,
                      input logic [NP-1:0] b);
    bus.card_valid = cv; bus.card_color = c; bus.card_num = n;
    bus.pot = p; bus.bell = b;
    model_edge(cv, c, n, p, b);
    @(posedge clk);
    @(negedge clk);
    check_outs();
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) tick(1'b0, '0, '0, '0, '0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic zero_outs(input string tag);
    chk({tag, "_rv"}, int'(bus.result_valid), 0);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_wv"}, int'(bus.winner_valid), 0);
    chk({tag, "_s0"}, sc(0), 0);
    chk({tag, "_s1"}, sc(1), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [NP*CW-1:0] rc;
    logic [NP*NW-1:0] rn;
    logic [PW-1:0]    rp;
    logic [NP-1:0]    rb;
    bus.card_valid = 1'b0; bus.card_color = '0; bus.card_num = '0;
    bus.pot = '0; bus.bell = '0;
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    zero_outs("reset");
    rst = 1'b1;

    // correct press with cards arriving on the same edge
    tick(1'b1, 4'b0000, 6'b011_010, 8'd6, 2'b01);
    tick(1'b0, '0, '0, '0, '0);
    chk("tp1_right", int'(bus.result_right), 1);
    chk("tp1_s0", sc(0), 6);
    chk("tp1_s1", sc(1), 0);
    idle(4);
    tick(1'b1, 4'b0100, 6'b001_101, 8'd7, 2'b10);
    idle(5);
    chk("tp2_s1", sc(1), 7);
    tick(1'b1, 4'b0100, 6'b001_100, 8'd7, 2'b10);
    idle(5);
    chk("tp3_s0", sc(0), 7);
    chk("tp3_s1", sc(1), 6);
    // simultaneous bells, then presses during JUDGE/LOCK are dropped
    tick(1'b0, '0, '0, 8'd3, 2'b11);
    for (int i = 0; i < 5; i++) tick(1'b0, '0, '0, 8'd3, 2'b11);
    tick(1'b0, '0, '0, 8'd3, 2'b11);
    idle(6);

    // press before any card is a wrong press
    do_reset();
    tick(1'b0, '0, '0, 8'd9, 2'b01);
    idle(5);
    chk("idle_s0", sc(0), -1);
    chk("idle_s1", sc(1), 1);

    // winner after a 51-point lead
    do_reset();
    tick(1'b1, 4'b0000, 6'b011_010, 8'd51, 2'b01);
    idle(2);
    chk("win_v", int'(bus.winner_valid), 1);
    chk("win_p", int'(bus.winner), 0);
    for (int i = 0; i < 12; i++)
      tick(1'b1, 4'b0000, 6'b011_010, 8'd9, 2'(i % 3 + 1));
    #2 rst = 1'b0;
    #1 zero_outs("async");
    model_reset();
    @(negedge clk);
    rst = 1'b1;

    // reset while a judgement is pending
    tick(1'b1, 4'b0000, 6'b011_010, 8'd20, 2'b01);
    rst = 1'b0;
    #1 zero_outs("midrst");
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    idle(3);

    // both players climb until scores saturate
    do_reset();
    for (int k = 0; k < 16; k++) begin
      tick(1'b1, 4'b0000, 6'b011_010, 8'd40, 2'(1 << (k % 2)));
      idle(5);
    end
    chk("sat_s0", sc(0), SMAX);

    do_reset();
    for (int i = 0; i < 500; i++) begin
      rc = NP*CW'($urandom);
      rn = NP*NW'($urandom);
      rp = PW'($urandom_range(0, 15));
      rb = ($urandom_range(0, 3) == 0) ? NP'($urandom) : '0;
      tick(($urandom_range(0, 2) == 0), rc, rn, rp, rb);
      if (i % 200 == 199) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
